// File: rtl/dtp_batch_ctrl_if.sv
// Host/dtp/result-BRAM bundle for dtp_batch_ctrl.
// master: host, dtp and BRAM side; slave: the controller.
interface dtp_batch_ctrl_if #(
  parameter int NUM_SAMP_WIDTH = 16,
  parameter int RES_ADDR_WIDTH = 10,
  parameter int RES_WIDTH      = 16
);
  logic                      i_start;
  logic                      i_abort;
  logic [NUM_SAMP_WIDTH-1:0] i_num_samp;
  logic [1:0]                i_bank_loaded;
  logic [1:0]                o_bank_free;
  logic                      o_bank_sel;
  logic                      o_dtp_start;
  logic                      i_dtp_fin;
  logic                      i_res_vld;
  logic [RES_WIDTH-1:0]      i_res_data;
  logic                      o_res_we;
  logic [RES_ADDR_WIDTH-1:0] o_res_addr;
  logic [RES_WIDTH-1:0]      o_res_din;
  logic [RES_ADDR_WIDTH:0]   o_res_cnt;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_res_ovf;

  modport master (
    output i_start, i_abort, i_num_samp,
    output i_bank_loaded, i_dtp_fin,
    output i_res_vld, i_res_data,
    input  o_bank_free, o_bank_sel, o_dtp_start,
    input  o_res_we, o_res_addr, o_res_din,
    input  o_res_cnt, o_busy, o_done, o_res_ovf
  );

  modport slave (
    input  i_start, i_abort, i_num_samp,
    input  i_bank_loaded, i_dtp_fin,
    input  i_res_vld, i_res_data,
    output o_bank_free, o_bank_sel, o_dtp_start,
    output o_res_we, o_res_addr, o_res_din,
    output o_res_cnt, o_busy, o_done, o_res_ovf
  );
endinterface

// File: rtl/dtp_batch_ctrl.sv
// Batch sequencer for the dtp: ping-pong bank tracking, start/fin
// sequencing and linear result-BRAM packing. Ports: clk, rst, bus(slave).
module dtp_batch_ctrl #(
  parameter int NUM_SAMP_WIDTH = 16,
  parameter int RES_ADDR_WIDTH = 10,
  parameter int RES_WIDTH      = 16
) (
  input logic clk,
  input logic rst,
  dtp_batch_ctrl_if.slave bus
);

  localparam int AW = RES_ADDR_WIDTH;
  localparam int NW = NUM_SAMP_WIDTH;
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
  localparam logic [AW:0]   CNT_MAX  = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAUNCH,
    S_RUN,
    S_SWITCH,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]           full_q, full_d;
  logic                 sel_q;
  logic [NW-1:0]        rem_q;
  logic [AW-1:0]        ptr_q;
  logic [AW-1:0]        addr_q;
  logic [RES_WIDTH-1:0] din_q;
  logic                 we_q;
  logic [AW:0]          cnt_q;
  logic                 ovf_q;

  logic busy, dtp_start, done;
  logic start_acc, cap;
  logic [1:0] clr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE:
        if (bus.i_start)
          state_d = (bus.i_num_samp != '0) ? S_WAIT : S_DONE;
      S_WAIT:
        if (full_q[sel_q]) state_d = S_LAUNCH;
      S_LAUNCH:
        state_d = S_RUN;
      S_RUN:
        if (bus.i_dtp_fin) state_d = S_SWITCH;
      S_SWITCH:
        state_d = (rem_q == NW'(1)) ? S_DONE : S_WAIT;
      default:
        state_d = S_IDLE;
    endcase
    if (bus.i_abort) state_d = S_IDLE;
  end

  always_comb begin
    busy      = 1'b0;
    dtp_start = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_WAIT, S_RUN, S_SWITCH: busy = 1'b1;
      S_LAUNCH: begin
        busy      = 1'b1;
        dtp_start = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign start_acc = (state_q == S_IDLE || state_q == S_DONE)
                   && bus.i_start && !bus.i_abort;
  assign cap = busy && bus.i_res_vld && !bus.i_abort;

  // Host load is OR-ed in after the clear so a same-cycle load wins.
  always_comb begin
    clr = 2'b00;
    if (state_q == S_SWITCH) clr = sel_q ? 2'b10 : 2'b01;
    full_d = (full_q & ~clr) | bus.i_bank_loaded;
    if (bus.i_abort) full_d = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      sel_q  <= 1'b0;
      rem_q  <= '0;
      ptr_q  <= '0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      we_q   <= cap;
      if (cap) begin
        din_q  <= bus.i_res_data;
        addr_q <= ptr_q;
        ptr_q  <= ptr_q + 1'b1;
        if (ptr_q == ADDR_MAX) ovf_q <= 1'b1;
        if (cnt_q != CNT_MAX)  cnt_q <= cnt_q + 1'b1;
      end
      if (start_acc) begin
        rem_q <= bus.i_num_samp;
        ptr_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
        sel_q <= 1'b0;
      end
      if (state_q == S_SWITCH && !bus.i_abort) begin
        sel_q <= ~sel_q;
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  assign bus.o_bank_free = ~full_q;
  assign bus.o_bank_sel  = sel_q;
  assign bus.o_dtp_start = dtp_start;
  assign bus.o_res_we    = we_q;
  assign bus.o_res_addr  = addr_q;
  assign bus.o_res_din   = din_q;
  assign bus.o_res_cnt   = cnt_q;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_res_ovf   = ovf_q;

endmodule

// File: doc/dtp_batch_ctrl.md
# dtp_batch_ctrl

Batch sequencer for the decision-tree processor (dtp). It runs one batch of N samples through the dtp. It tracks the two ping-pong attribute-RAM banks that the host fills, pulses the dtp start for each loaded sample, and switches banks on each dtp finish. It also packs dtp results into a linear result BRAM and reports done, count and overflow back to the register bank.

## Interface
- NUM_SAMP_WIDTH, 16, width of the sample-count field
- RES_ADDR_WIDTH, 10, result BRAM word-address width
- RES_WIDTH, 16, result word width
- clk  in  1  the single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse that begins a batch
- i_abort  in  1  one-cycle pulse that kills the batch
- i_num_samp  in  NUM_SAMP_WIDTH  samples in the batch; latched on an accepted i_start
- i_bank_loaded  in  2  bit b pulses when the host has finished writing a sample into bank b
- o_bank_free  out  2  bit b is high when bank b may be written by the host
- o_bank_sel  out  1  bank currently read by the dtp (drives the attribute-RAM switch)
- o_dtp_start  out  1  start pulse to the dtp
- i_dtp_fin  in  1  pulse: dtp is done with the current sample
- i_res_vld  in  1  dtp result word valid
- i_res_data  in  RES_WIDTH  dtp result word
- o_res_we  out  1  result BRAM write enable
- o_res_addr  out  RES_ADDR_WIDTH  result BRAM word address
- o_res_din  out  RES_WIDTH  result BRAM write data
- o_res_cnt  out  RES_ADDR_WIDTH+1  result words written in this batch
- o_busy  out  1  batch in progress
- o_done  out  1  batch completed; held high until the next start or abort
- o_res_ovf  out  1  sticky flag: result BRAM wrapped

## Operation
- **States:** IDLE, WAIT_BANK, LAUNCH, RUN, SWITCH, DONE.
- **Reset:** state IDLE; bank_full=2'b00, so o_bank_free=2'b11; all other outputs 0.
- **Bank flags:**
  - bank_full[b] sets on i_bank_loaded[b] in any state.
  - bank_full[bank_sel] clears in SWITCH.
  - If set and clear hit the same bit in the same cycle, set wins.
  - o_bank_free = ~bank_full.
- **IDLE or DONE + i_start:**
  - Latch remaining = i_num_samp.
  - Zero the result address, count and o_res_ovf; clear o_done; set bank_sel=0.
  - If i_num_samp != 0, go to WAIT_BANK. If i_num_samp == 0, go to DONE.
- **WAIT_BANK:** when bank_full[bank_sel] is set, go to LAUNCH.
- **LAUNCH:** o_dtp_start=1 for exactly this cycle, then go to RUN.
- **RUN:** when i_dtp_fin arrives, go to SWITCH. i_dtp_fin is ignored in every other state.
- **SWITCH:**
  - Clear bank_full[bank_sel], toggle bank_sel, decrement remaining.
  - If remaining was 1, go to DONE; otherwise go to WAIT_BANK.
- **DONE:** o_done=1 and o_busy=0. Stays in DONE until i_start or i_abort.
- **o_busy:** high in WAIT_BANK, LAUNCH, RUN and SWITCH.
- **i_start while o_busy:** ignored.
- **i_abort (any state):**
  - Go to IDLE next cycle and clear bank_full to 00.
  - o_done=0; no further result writes.
  - The result count is kept for readback.
  - i_abort has priority over i_start in the same cycle.
- **Result capture:**
  - Any i_res_vld seen while o_busy writes i_res_data at the current address, then address+1 and o_res_cnt+1.
  - Address wraps from 2^RES_ADDR_WIDTH-1 to 0 and sets o_res_ovf.
  - o_res_cnt saturates at 2^RES_ADDR_WIDTH.
- **i_res_vld with i_dtp_fin in the same cycle:** the result is written and the switch still proceeds.

## Timing
- o_dtp_start, o_busy and o_done decode directly from the state register.
- Bank-to-start latency:
  - i_bank_loaded pulse at cycle t (already in WAIT_BANK, with bank_sel matching) → bank_full set at t+1 → LAUNCH and o_dtp_start at t+2.
  - If the flag was already set on entry to WAIT_BANK, o_dtp_start comes one cycle after entry.
- i_dtp_fin at cycle t → SWITCH at t+1. o_bank_sel toggles, and the freed bank's o_bank_free rises, at t+2.
- Result write path is registered: i_res_vld/i_res_data at cycle t → o_res_we=1 with o_res_addr and o_res_din at t+1. o_res_cnt updates at t+1.
- Back-to-back i_res_vld is supported at one write per cycle.
- A result presented in the abort cycle is dropped.
- Minimum per-sample overhead with both banks preloaded: SWITCH + WAIT_BANK + LAUNCH = 3 cycles from i_dtp_fin to the next o_dtp_start.

## Test plan
- **Reset check:** assert rst for 2 cycles → o_bank_free=11, o_bank_sel=0, and every other output 0.
- **Single sample:**
  - Stimulus: i_num_samp=1, start, load bank0, dtp returns 3 results, then fin.
  - Required: o_dtp_start exactly once; writes to addresses 0, 1, 2; o_res_cnt=3; o_done=1 two cycles after fin; o_bank_free=11.
- **Four samples, ping-pong:**
  - Stimulus: banks alternate 0,1,0,1, with the host loading only while o_bank_free is high.
  - Required: o_bank_sel sequence 0,1,0,1; 4 start pulses; done after the 4th fin.
  - Also cover a delayed load: start must wait in WAIT_BANK until the load arrives.
- **Zero count:** i_num_samp=0 with start → o_done=1 next cycle; no o_dtp_start; o_res_cnt=0.
- **Wrap and overflow:**
  - Stimulus: RES_ADDR_WIDTH=2, five results.
  - Required: addresses 0, 1, 2, 3, 0; o_res_ovf=1; o_res_cnt=4 (saturated).
- **Abort and collisions:**
  - Abort during RUN, in the same cycle as i_res_vld → no write, IDLE next cycle, o_bank_free=11.
  - Start again → the batch runs normally.
  - i_bank_loaded on bank_sel during SWITCH → that bank stays full.
